// File: rtl/afu_port_rst_ctrl.sv
// Per-port FLR sequencer: drain TX, hold AFU reset, then report completion via one RR-arbitered response.
// Define AFU_PORT_RST_TIMEOUT_EN to bound the DRAIN phase by DRAIN_TIMEOUT cycles.

module afu_port_fsm #(
  parameter int RST_HOLD_CYCLES = 16,
  parameter int DRAIN_TIMEOUT   = 1024,
  parameter bit TO_EN           = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic tx_active,
  input  logic rsp_done,
  output logic idle,
  output logic pend,
  output logic in_rst,
  output logic to_flag
);
  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_RESET, S_RESP} state_t;

  localparam logic [15:0] HOLD_LAST = 16'(RST_HOLD_CYCLES - 1);
  localparam logic [15:0] TO_LAST   = 16'(DRAIN_TIMEOUT - 1);

  state_t      state, nxt;
  logic [15:0] cnt;
  logic        to_hit;

  // With TO_EN clear this folds to 0 and the DRAIN counting logic disappears.
  assign to_hit = TO_EN && (state == S_DRAIN) && (cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (start)                nxt = S_DRAIN;
      S_DRAIN: if (!tx_active || to_hit) nxt = S_RESET;
      S_RESET: if (cnt == HOLD_LAST)     nxt = S_RESP;
      S_RESP:  if (rsp_done)             nxt = S_IDLE;
      default:                           nxt = S_IDLE;
    endcase
  end

  // Saturating counter, cleared on every state entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (nxt != state)
      cnt <= '0;
    else if ((state == S_RESET || (TO_EN && state == S_DRAIN)) && cnt != 16'hFFFF)
      cnt <= cnt + 16'd1;
  end

  generate
    if (TO_EN) begin : g_to
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  to_flag <= 1'b0;
        else if (to_hit && tx_active) to_flag <= 1'b1;
      end
    end else begin : g_no_to
      assign to_flag = 1'b0;
    end
  endgenerate

  assign idle   = (state == S_IDLE);
  assign pend   = (state == S_RESP);
  assign in_rst = (state == S_RESET);
endmodule

module afu_port_rst_ctrl #(
  parameter int NUM_PORTS       = 4,
  parameter int RST_HOLD_CYCLES = 16,
  parameter int DRAIN_TIMEOUT   = 1024,
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flr_req_valid,
  input  logic [PW-1:0]        flr_req_port,
  input  logic [NUM_PORTS-1:0] port_tx_active,
  input  logic                 flr_rsp_ready,
  output logic                 flr_rsp_valid,
  output logic [PW-1:0]        flr_rsp_port,
  output logic [NUM_PORTS-1:0] port_tx_block,
  output logic [NUM_PORTS-1:0] port_rst_n,
  output logic                 err_dup_req,
  output logic [NUM_PORTS-1:0] drain_timeout
);
`ifdef AFU_PORT_RST_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic                 rst_q;
  logic [NUM_PORTS-1:0] idle, pend, in_rst, start, rsp_done, to_flag;
  logic                 in_range, idle_sel, gnt_found;
  logic [PW-1:0]        ptr, gnt_idx;

  assign in_range = ({1'b0, flr_req_port} < (PW+1)'(NUM_PORTS));

  always_comb begin
    idle_sel = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++)
      if (flr_req_port == PW'(p)) idle_sel = idle[p];
  end

  generate
    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
      assign start[g]    = flr_req_valid & in_range & (flr_req_port == PW'(g)) & idle[g];
      assign rsp_done[g] = flr_rsp_valid & flr_rsp_ready & (flr_rsp_port == PW'(g));

      afu_port_fsm #(
        .RST_HOLD_CYCLES(RST_HOLD_CYCLES),
        .DRAIN_TIMEOUT  (DRAIN_TIMEOUT),
        .TO_EN          (TO_EN)
      ) u_fsm (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start[g]),
        .tx_active(port_tx_active[g]),
        .rsp_done (rsp_done[g]),
        .idle     (idle[g]),
        .pend     (pend[g]),
        .in_rst   (in_rst[g]),
        .to_flag  (to_flag[g])
      );
    end
  endgenerate

  // Round robin: lowest pending port at or above ptr, else lowest pending overall.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int p = 0; p < NUM_PORTS; p++)
      if (!gnt_found && pend[p] && PW'(p) >= ptr) begin
        gnt_found = 1'b1;
        gnt_idx   = PW'(p);
      end
    for (int p = 0; p < NUM_PORTS; p++)
      if (!gnt_found && pend[p]) begin
        gnt_found = 1'b1;
        gnt_idx   = PW'(p);
      end
  end

  // Grants only while the response register is empty, so a handshake cycle never re-grants.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flr_rsp_valid <= 1'b0;
      flr_rsp_port  <= '0;
      ptr           <= '0;
    end else if (flr_rsp_valid) begin
      if (flr_rsp_ready) begin
        flr_rsp_valid <= 1'b0;
        ptr <= (flr_rsp_port == PW'(NUM_PORTS - 1)) ? '0 : flr_rsp_port + PW'(1);
      end
    end else if (gnt_found) begin
      flr_rsp_valid <= 1'b1;
      flr_rsp_port  <= gnt_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                          err_dup_req <= 1'b0;
    else if (flr_req_valid && (!in_range || !idle_sel)) err_dup_req <= 1'b1;
  end

  // Holds every port in reset until the first edge after rst_n releases.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_q <= 1'b0;
    else        rst_q <= 1'b1;
  end

  assign port_tx_block = ~idle;
  assign port_rst_n    = {NUM_PORTS{rst_q}} & ~in_rst;
  assign drain_timeout = to_flag;
endmodule

// File: tb/tb_afu_port_rst_ctrl.sv
// Directed bench for afu_port_rst_ctrl (NUM_PORTS=4, RST_HOLD_CYCLES=16).
module tb_afu_port_rst_ctrl;
  localparam int NP = 4;
  localparam int PW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flr_req_valid;
  logic [PW-1:0] flr_req_port;
  logic [NP-1:0] port_tx_active;
  logic          flr_rsp_ready;
  logic          flr_rsp_valid;
  logic [PW-1:0] flr_rsp_port;
  logic [NP-1:0] port_tx_block;
  logic [NP-1:0] port_rst_n;
  logic          err_dup_req;
  logic [NP-1:0] drain_timeout;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int rsp_port_q[$];
  int rsp_cyc_q[$];

  afu_port_rst_ctrl #(.NUM_PORTS(NP), .RST_HOLD_CYCLES(16), .DRAIN_TIMEOUT(1024)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flr_req_valid (flr_req_valid),
    .flr_req_port  (flr_req_port),
    .port_tx_active(port_tx_active),
    .flr_rsp_ready (flr_rsp_ready),
    .flr_rsp_valid (flr_rsp_valid),
    .flr_rsp_port  (flr_rsp_port),
    .port_tx_block (port_tx_block),
    .port_rst_n    (port_rst_n),
    .err_dup_req   (err_dup_req),
    .drain_timeout (drain_timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Each observed valid&ready is one handshake at the following edge.
  always @(negedge clk)
    if (rst_n && flr_rsp_valid && flr_rsp_ready) begin
      rsp_port_q.push_back(int'(flr_rsp_port));
      rsp_cyc_q.push_back(cyc);
    end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input int p);
    flr_req_valid = 1'b1;
    flr_req_port  = PW'(p);
    tick();
    flr_req_valid = 1'b0;
  endtask

  initial begin
    int c0;
    int low;
    rst_n          = 1'b0;
    flr_req_valid  = 1'b0;
    flr_req_port   = '0;
    port_tx_active = '0;
    flr_rsp_ready  = 1'b1;
    repeat (3) tick();

    // reset values
    chk("rst_valid", 32'(flr_rsp_valid), 0);
    chk("rst_port", 32'(flr_rsp_port), 0);
    chk("rst_rst_n", 32'(port_rst_n), 0);
    chk("rst_block", 32'(port_tx_block), 0);
    chk("rst_err", 32'(err_dup_req), 0);
    chk("rst_dto", 32'(drain_timeout), 0);
    rst_n = 1'b1;
    tick();
    chk("rst_release", 32'(port_rst_n), 32'hF);

    // single FLR on idle port 2
    req(2);
    c0 = cyc;
    chk("t1_block_on", 32'(port_tx_block[2]), 1);
    chk("t1_rst_drain", 32'(port_rst_n[2]), 1);
    low = 0;
    for (int i = 1; i <= 25; i++) begin
      tick();
      if (!port_rst_n[2]) low++;
      if (i == 18) chk("t1_block_rsp", 32'(port_tx_block[2]), 1);
      if (i == 19) chk("t1_block_off", 32'(port_tx_block[2]), 0);
    end
    chk("t1_low_cycles", 32'(low), 16);
    chk("t1_nrsp", 32'(rsp_port_q.size()), 1);
    if (rsp_port_q.size() == 1) begin
      chk("t1_port", 32'(rsp_port_q[0]), 2);
      chk("t1_latency", 32'(rsp_cyc_q[0] - c0), 18);
    end
    rsp_port_q.delete(); rsp_cyc_q.delete();

    // port 1 held in DRAIN by an active packet
    port_tx_active[1] = 1'b1;
    req(1);
    low = 0;
    repeat (50) begin
      tick();
      if (!port_rst_n[1]) low++;
    end
    chk("t2_no_reset", 32'(low), 0);
    chk("t2_block", 32'(port_tx_block[1]), 1);
    chk("t2_no_rsp", 32'(rsp_port_q.size()), 0);
    port_tx_active[1] = 1'b0;
    repeat (25) begin
      tick();
      if (!port_rst_n[1]) low++;
    end
    chk("t2_low_cycles", 32'(low), 16);
    chk("t2_nrsp", 32'(rsp_port_q.size()), 1);
    if (rsp_port_q.size() == 1) chk("t2_port", 32'(rsp_port_q[0]), 1);
    rsp_port_q.delete(); rsp_cyc_q.delete();

    // back-to-back requests 0,3,1 -> round robin order 0,1,3
    req(0);
    c0 = cyc;
    req(3);
    req(1);
    repeat (30) tick();
    chk("t3_nrsp", 32'(rsp_port_q.size()), 3);
    if (rsp_port_q.size() == 3) begin
      chk("t3_port0", 32'(rsp_port_q[0]), 0);
      chk("t3_port1", 32'(rsp_port_q[1]), 1);
      chk("t3_port2", 32'(rsp_port_q[2]), 3);
      chk("t3_cyc0", 32'(rsp_cyc_q[0] - c0), 18);
      chk("t3_cyc1", 32'(rsp_cyc_q[1] - c0), 20);
      chk("t3_cyc2", 32'(rsp_cyc_q[2] - c0), 22);
    end
    rsp_port_q.delete(); rsp_cyc_q.delete();

    // duplicate request during RESET
    chk("t4_err_pre", 32'(err_dup_req), 0);
    req(0);
    repeat (5) tick();
    chk("t4_in_reset", 32'(port_rst_n[0]), 0);
    req(0);
    chk("t4_err_set", 32'(err_dup_req), 1);
    repeat (30) tick();
    chk("t4_nrsp", 32'(rsp_port_q.size()), 1);
    if (rsp_port_q.size() == 1) chk("t4_port", 32'(rsp_port_q[0]), 0);
    rsp_port_q.delete(); rsp_cyc_q.delete();

    // port 3 stuck mid-packet
    port_tx_active[3] = 1'b1;
    req(3);
    for (int i = 1; i <= 1100; i++) begin
      tick();
`ifdef AFU_PORT_RST_TIMEOUT_EN
      if (i == 1023) chk("t5_pre_to", 32'(port_rst_n[3]), 1);
      if (i == 1024) begin
        chk("t5_to_reset", 32'(port_rst_n[3]), 0);
        chk("t5_to_flag", 32'(drain_timeout[3]), 1);
      end
`endif
    end
`ifdef AFU_PORT_RST_TIMEOUT_EN
    chk("t5_nrsp", 32'(rsp_port_q.size()), 1);
`else
    chk("t5_nrsp", 32'(rsp_port_q.size()), 0);
    chk("t5_block", 32'(port_tx_block[3]), 1);
    chk("t5_rst_n", 32'(port_rst_n[3]), 1);
    chk("t5_dto", 32'(drain_timeout), 0);
`endif
    rsp_port_q.delete(); rsp_cyc_q.delete();

    // reset while a response is stalled
    flr_rsp_ready = 1'b0;
    req(2);
    repeat (20) tick();
    chk("t6_valid", 32'(flr_rsp_valid), 1);
    chk("t6_port", 32'(flr_rsp_port), 2);
    repeat (5) tick();
    chk("t6_hold_valid", 32'(flr_rsp_valid), 1);
    chk("t6_hold_port", 32'(flr_rsp_port), 2);
    rst_n = 1'b0;
    #2;
    chk("t6_rst_valid", 32'(flr_rsp_valid), 0);
    chk("t6_rst_port", 32'(flr_rsp_port), 0);
    chk("t6_rst_rst_n", 32'(port_rst_n), 0);
    chk("t6_rst_block", 32'(port_tx_block), 0);
    chk("t6_rst_err", 32'(err_dup_req), 0);
    chk("t6_rst_dto", 32'(drain_timeout), 0);
    port_tx_active = '0;
    flr_rsp_ready  = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("t6_release", 32'(port_rst_n), 32'hF);
    repeat (10) tick();
    chk("t6_no_rsp", 32'(rsp_port_q.size()), 0);
    chk("t6_idle", 32'(port_tx_block), 0);
    req(2);
    c0 = cyc;
    repeat (25) tick();
    chk("t6_nrsp", 32'(rsp_port_q.size()), 1);
    if (rsp_port_q.size() == 1) chk("t6_latency", 32'(rsp_cyc_q[0] - c0), 18);
    chk("t6_err_clean", 32'(err_dup_req), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
